score_display_bcd: RTL and testbench
====================================

// Module: score_display_bcd
// PURPOSE
//  Parametrised game-score counter and 7-segment driver for the flappy-bird datapath.
//  - Keeps an N-digit BCD score that advances while the bird is alive, from an internal prescaler tick or an external pipe-passed pulse.
//  - Freezes the score on death, keeps a high score, and drives one active-low 7-seg display per digit.
// PARAMETERS
//  NUM_DIGITS  3   number of BCD digits / HEX displays (1..6)
//  TICK_DIV    10  clocks per auto-increment tick (>=1)
//  AUTO_TICK   1   1: prescaler tick and score_pulse both increment; 0: score_pulse only
// PORTS
//  clk         in   1              system clock, all state on rising edge
//  reset       in   1              asynchronous, active-low (0 = reset)
//  is_dead     in   1              level; 1 = bird dead, score frozen
//  score_pulse in   1              single-cycle point event (pipe passed)
//  clear       in   1              synchronous score restart; high score kept
//  show_high   in   1              1: displays show high score, 0: current score
//  hex         out  7*NUM_DIGITS   segments, digit i at [7i+6:7i], bit0=a..bit6=g, active-low
//  score_bcd   out  4*NUM_DIGITS   current score, digit i at [4i+3:4i]
//  high_bcd    out  4*NUM_DIGITS   high score
//  saturated   out  1              1 when score is all 9s
// BEHAVIOUR
//  Reset (async, reset=0): score=0, high=0, prescaler=0, state=ALIVE, saturated=0.
//   - hex digits = 7'h40 ("0").
//  States: ALIVE (is_dead=0) and DEAD (is_dead=1), evaluated every cycle from the sampled is_dead.
//  Prescaler:
//   - counts 0..TICK_DIV-1 only in ALIVE, not saturated, AUTO_TICK=1.
//   - tick when count==TICK_DIV-1, count returns to 0.
//   - holds its value in DEAD.
//  Increment:
//   - inc = (tick | score_pulse) & ~is_dead & ~saturated.
//   - tick and pulse in the same cycle add 1, not 2.
//   - score updates at the clock edge that samples inc; 1-cycle latency.
//  BCD arithmetic: digit 9 with carry-in -> 0, carry to the next digit; all-9s score holds; saturated = (score == all 9s).
//  Death onset (ALIVE->DEAD edge):
//   - is_dead sampled 1 blocks any increment in that cycle.
//   - same edge: high <= score if score > high (lexicographic BCD compare, MS digit first).
//   - high is visible the cycle after onset.
//  Clear:
//   - priority over increment; score=0, prescaler=0, saturated=0; high unchanged; state unchanged.
//   - clear during DEAD keeps the score frozen at 0 until is_dead falls.
//  Display:
//   - hex is combinational from the registered score_bcd/high_bcd (mux by show_high); 0 display latency.
//   - encoding 0..9 = 40,79,24,30,19,12,02,78,00,10 (hex); non-BCD nibble = 7'h7F (blank).
//  Reset mid-run clears high as well; only reset clears high.
// CONFIGURATION
//  SCORE_LZ_BLANK_EN defined:
//   - leading-zero digits (every digit above the highest nonzero digit) show 7'h7F.
//   - digit 0 is never blanked.
//   - applies to both score and high views.
//  SCORE_LZ_BLANK_EN undefined: every digit always shows its numeral, including leading zeros.
// TESTING (NUM_DIGITS=3, TICK_DIV=10 unless noted)
//  1 Reset:
//    reset=0 then 1, is_dead=1 -> score_bcd=12'h000, hex=21'h102040 (all "0").
//    With SCORE_LZ_BLANK_EN: hex[20:7]=all 1s.
//  2 Auto tick: is_dead=0 for 100 clk -> score_bcd=12'h010, hex[13:7]=7'h79.
//    Set is_dead=1, wait 50 clk -> unchanged.
//  3 Pulse only (AUTO_TICK=0): 12 score_pulse -> 12'h012.
//    Pulse while is_dead=1 -> still 12'h012.
//    Pulse coincident with tick (AUTO_TICK=1) -> +1 only.
//  4 High score: die at 015 -> high_bcd=12'h015.
//    clear, run to 007, die -> high stays 015.
//    show_high=1 -> hex shows 015.
//  5 Saturation (NUM_DIGITS=2, TICK_DIV=1): alive 120 clk -> score_bcd=8'h99, saturated=1, no wrap.
//    clear -> 8'h00, saturated=0.
//  6 Reset mid-run: at score 037 with high 015, assert reset between clock edges -> score and high 0 immediately.
//    Prescaler restarts from 0.

Source files
------------

// File: rtl/score_display_bcd.sv
// N-digit BCD game-score counter with high-score capture and active-low 7-segment drive.
// Optional build macro SCORE_LZ_BLANK_EN blanks leading-zero digits (digit 0 always shown).
module score_display_bcd #(
    parameter int NUM_DIGITS = 3,
    parameter int TICK_DIV   = 10,
    parameter int AUTO_TICK  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    is_dead,
    input  logic                    score_pulse,
    input  logic                    clear,
    input  logic                    show_high,
    output logic [7*NUM_DIGITS-1:0] hex,
    output logic [4*NUM_DIGITS-1:0] score_bcd,
    output logic [4*NUM_DIGITS-1:0] high_bcd,
    output logic                    saturated
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] PRESC_LAST = CW'(TICK_DIV - 1);

    typedef enum logic {
        ST_ALIVE,
        ST_DEAD
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [CW-1:0]           r_presc;
    logic [CW-1:0]           w_presc_next;
    logic [4*NUM_DIGITS-1:0] r_score;
    logic [4*NUM_DIGITS-1:0] r_high;
    logic [4*NUM_DIGITS-1:0] w_score_inc;
    logic [4*NUM_DIGITS-1:0] w_disp;
    logic                    w_sat;
    logic                    w_tick;
    logic                    w_inc;
    logic                    w_onset;
    logic                    w_carry;
    logic                    w_presc_en;
    logic                    w_seen_nz;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    always_comb begin
        w_sat = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (r_score[4*i +: 4] != 4'd9) w_sat = 1'b0;
        end
    end

    assign w_presc_en = (AUTO_TICK != 0) && !is_dead && !w_sat;
    assign w_tick     = w_presc_en && (r_presc == PRESC_LAST);
    assign w_inc      = (w_tick | score_pulse) & ~is_dead & ~w_sat;

    always_comb begin
        w_presc_next = r_presc;
        if (clear)           w_presc_next = '0;
        else if (w_tick)     w_presc_next = '0;
        else if (w_presc_en) w_presc_next = r_presc + 1'b1;
    end

    // Ripple BCD +1: a 9 receiving carry rolls to 0 and passes the carry on.
    always_comb begin
        w_score_inc = r_score;
        w_carry     = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (w_carry) begin
                if (r_score[4*i +: 4] == 4'd9) begin
                    w_score_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_score_inc[4*i +: 4] = r_score[4*i +: 4] + 4'd1;
                    w_carry               = 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_state_next = is_dead ? ST_DEAD : ST_ALIVE;
        w_onset      = (r_state == ST_ALIVE) && is_dead;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_ALIVE;
            r_presc <= '0;
            r_score <= '0;
            r_high  <= '0;
        end else begin
            r_state <= w_state_next;
            r_presc <= w_presc_next;
            if (clear)      r_score <= '0;
            else if (w_inc) r_score <= w_score_inc;
            // Packed unsigned compare of valid BCD equals an MS-digit-first digit compare.
            if (w_onset && (r_score > r_high)) r_high <= r_score;
        end
    end

    assign score_bcd = r_score;
    assign high_bcd  = r_high;
    assign saturated = w_sat;
    assign w_disp    = show_high ? r_high : r_score;

    always_comb begin
        hex       = '1;
        w_seen_nz = 1'b0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            int unsigned idx;
            idx = NUM_DIGITS - 1 - k;
            if (w_disp[4*idx +: 4] != 4'd0) w_seen_nz = 1'b1;
`ifdef SCORE_LZ_BLANK_EN
            if (!w_seen_nz && (idx != 0)) hex[7*idx +: 7] = 7'h7F;
            else                          hex[7*idx +: 7] = seg7(w_disp[4*idx +: 4]);
`else
            hex[7*idx +: 7] = seg7(w_disp[4*idx +: 4]);
`endif
        end
    end

endmodule

// File: tb/tb_score_display_bcd.sv
// Self-checking bench for score_display_bcd: directed steps plus random phase against an integer score model.
module tb_score_display_bcd;

    localparam int ND   = 3;
    localparam int TD   = 10;
    localparam int MAXV = 999;
    localparam logic [6:0] SEG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                        7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    logic            clk = 1'b0;
    logic            reset;
    logic            is_dead;
    logic            score_pulse;
    logic            clear;
    logic            show_high;
    logic [7*ND-1:0] hex;
    logic [4*ND-1:0] score_bcd;
    logic [4*ND-1:0] high_bcd;
    logic            saturated;

    int errors = 0;
    int checks = 0;
    int m_score, m_high, m_pres;
    bit m_dead;

    score_display_bcd #(.NUM_DIGITS(ND), .TICK_DIV(TD), .AUTO_TICK(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .is_dead     (is_dead),
        .score_pulse (score_pulse),
        .clear       (clear),
        .show_high   (show_high),
        .hex         (hex),
        .score_bcd   (score_bcd),
        .high_bcd    (high_bcd),
        .saturated   (saturated)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] exp_hex(input int v);
        logic [31:0] r;
        int p;
        bit blank;
        r = '0;
        p = 1;
        for (int i = 0; i < ND; i++) begin
            blank = 1'b0;
`ifdef SCORE_LZ_BLANK_EN
            blank = (i > 0) && (v < p);
`endif
            r[7*i +: 7] = blank ? 7'h7F : SEG[(v / p) % 10];
            p = p * 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_score = 0;
        m_high  = 0;
        m_pres  = 0;
        m_dead  = 1'b0;
    endtask

    // One clock edge of the game rules, using the inputs held across that edge.
    task automatic model_step();
        int  old;
        bit  tick;
        old = m_score;
        if (clear) begin
            m_score = 0;
            m_pres  = 0;
        end else if (!is_dead && m_score < MAXV) begin
            tick   = (m_pres == TD - 1);
            m_pres = tick ? 0 : m_pres + 1;
            if (tick || score_pulse) m_score = m_score + 1;
        end
        if (is_dead && !m_dead && old > m_high) m_high = old;
        m_dead = is_dead;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".score"}, 32'(score_bcd), to_bcd(m_score));
        chk({tag, ".high"},  32'(high_bcd),  to_bcd(m_high));
        chk({tag, ".sat"},   32'(saturated), 32'(m_score == MAXV));
        chk({tag, ".hex"},   32'(hex),       exp_hex(show_high ? m_high : m_score));
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    initial begin
        reset = 1'b0; is_dead = 1'b1; score_pulse = 1'b0; clear = 1'b0; show_high = 1'b0;
        model_reset();
        #12;
        check_all("reset");
`ifdef SCORE_LZ_BLANK_EN
        chk("reset.lzblank", 32'(hex[20:7]), 32'h3FFF);
`else
        chk("reset.hexconst", 32'(hex), 32'h102040);
`endif
        reset = 1'b1;
        repeat (2) cyc("post_reset");

        is_dead = 1'b0;
        repeat (100) cyc("auto");
        chk("auto.010", 32'(score_bcd), 32'h010);
        chk("auto.hex1", 32'(hex[13:7]), 32'h79);

        is_dead = 1'b1;
        repeat (50) cyc("dead_hold");
        chk("dead.010", 32'(score_bcd), 32'h010);
        score_pulse = 1'b1;
        cyc("dead_pulse");
        score_pulse = 1'b0;
        chk("dead_pulse.010", 32'(score_bcd), 32'h010);

        is_dead = 1'b0;
        repeat (49) cyc("to015");
        score_pulse = 1'b1;
        cyc("pulse_on_tick");
        score_pulse = 1'b0;
        chk("coincident.015", 32'(score_bcd), 32'h015);
        is_dead = 1'b1;
        cyc("die015");
        chk("high.015", 32'(high_bcd), 32'h015);

        clear = 1'b1;
        cyc("clear_dead");
        clear = 1'b0;
        repeat (3) cyc("frozen0");
        is_dead = 1'b0;
        repeat (70) cyc("to007");
        chk("score.007", 32'(score_bcd), 32'h007);
        is_dead = 1'b1;
        cyc("die007");
        chk("high.keep015", 32'(high_bcd), 32'h015);
        show_high = 1'b1;
        #1;
        chk("show_high.hex", 32'(hex), exp_hex(15));
        show_high = 1'b0;

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) < 4) is_dead = ~is_dead;
            score_pulse = ($urandom_range(0, 99) < 30);
            clear       = ($urandom_range(0, 99) < 2);
            show_high   = $urandom_range(0, 1) == 1;
            cyc("random");
        end
        score_pulse = 1'b0; clear = 1'b0; show_high = 1'b0;

        clear = 1'b1; is_dead = 1'b0;
        cyc("sat_clear");
        clear = 1'b0; score_pulse = 1'b1;
        repeat (1010) cyc("sat_run");
        chk("sat.999", 32'(score_bcd), 32'h999);
        chk("sat.flag", 32'(saturated), 32'h1);
        score_pulse = 1'b0;
        clear = 1'b1;
        cyc("sat_release");
        clear = 1'b0;
        chk("sat.cleared", 32'(score_bcd), 32'h000);
        chk("sat.flag0", 32'(saturated), 32'h0);

        repeat (37) cyc("pre_reset_run");
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk("midreset.score", 32'(score_bcd), 32'h000);
        chk("midreset.high",  32'(high_bcd),  32'h000);
        check_all("midreset");
        #3;
        reset = 1'b1;
        repeat (9) cyc("presc_restart");
        chk("presc.9clk", 32'(score_bcd), 32'h000);
        cyc("presc_restart");
        chk("presc.10clk", 32'(score_bcd), 32'h001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout: observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
